// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: retires DIGITS_PER_CYCLE Booth digits per clock
// into a wrapping accumulator, with valid/ready handshakes on both sides.
module booth_mul_seq #(
  parameter int WIDTH            = 16,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int N     = WIDTH/2 + 1;
  localparam int XW    = WIDTH + 2;
  localparam int ACC_W = 2*WIDTH + 4;
  localparam int CNT_W = $clog2(N + DIGITS_PER_CYCLE + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [XW:0]        xe_q, xe_d;    // extended x with the implicit bit -1 = 0 appended
  logic [XW-1:0]      ye_q, ye_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [ACC_W-1:0]   sum, mag, ye_sx;
  logic [CNT_W-1:0]   j;
  logic [2:0]         bits;
  logic               neg, one, two, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xe_q    <= '0;
      ye_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Sum of this cycle's partial products; digits at index >= N contribute nothing.
  always_comb begin
    ye_sx = {{(ACC_W-XW){ye_q[XW-1]}}, ye_q};
    sum   = acc_q;
    j     = '0;
    bits  = '0;
    neg   = 1'b0;
    one   = 1'b0;
    two   = 1'b0;
    mag   = '0;
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      j    = cnt_q + CNT_W'(k);
      bits = 3'(xe_q >> {j, 1'b0});
      neg  = bits[2];
      one  = bits[0] ^ bits[1];
      two  = (bits == 3'b011) || (bits == 3'b100);
      mag  = two ? (ye_sx << 1) : ye_sx;
      mag  = mag << {j, 1'b0};
      if ((int'(j) < N) && (one || two))
        sum = sum + (neg ? ~mag : mag) + ACC_W'(neg);
    end
  end

  assign last = (int'(cnt_q) + DIGITS_PER_CYCLE) >= N;

  always_comb begin
    state_d = state_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (in_valid) begin
        xe_d    = {(in_signed ? {2{x[WIDTH-1]}} : 2'b00), x, 1'b0};
        ye_d    = {(in_signed ? {2{y[WIDTH-1]}} : 2'b00), y};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(DIGITS_PER_CYCLE);
        if (last) begin
          prod_d  = sum[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule
